pctrl_tx: RTL and testbench



---
 rtl/pctrl_pkg.sv | 19 +
 rtl/pctrl_shreg.sv | 27 ++
 rtl/pctrl_tx.sv | 125 ++++++++++++
 tb/tb_pctrl_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pctrl_pkg.sv
// Shared definitions for the single-wire peripheral control link: field widths,
// frame length, line levels and the transmitter state encoding.
package pctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_OP_W   = 3;
  localparam int DEF_DATA_W = 62;
  localparam int FRAME_W    = 1 + DEF_ADDR_W + DEF_OP_W + DEF_DATA_W;

  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pctrl_shreg.sv
// Parallel-load, MSB-first shift register feeding the serial line.
module pctrl_shreg
  import pctrl_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_din,
  output logic         o_msb
);

  logic [W-1:0] r_sh;

  // Pure datapath: contents are meaningless until the first load, so no reset.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_sh <= i_din;
    end else if (i_shift) begin
      r_sh <= {r_sh[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[W-1];

endmodule

// File: rtl/pctrl_tx.sv
// Serial frame transmitter: start bit, address, opcode, data MSB-first, then an
// idle-high gap. Defining PCTRL_TX_PARITY_EN appends an even-parity bit.
module pctrl_tx
  import pctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] address,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              done
);

`ifdef PCTRL_TX_PARITY_EN
  localparam int PAY_W = ADDR_W + OP_W + DATA_W + 1;
`else
  localparam int PAY_W = ADDR_W + OP_W + DATA_W;
`endif
  localparam int CW  = $clog2(PAY_W + 1);
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(PAY_W);

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_cnt;
  logic [GCW-1:0]   r_gcnt;
  logic             r_tx;
  logic             r_done;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_msb;
  logic [PAY_W-1:0] w_payload;

`ifdef PCTRL_TX_PARITY_EN
  assign w_payload = {address, opcode, data, ^{address, opcode, data}};
`else
  assign w_payload = {address, opcode, data};
`endif

  pctrl_shreg #(.W(PAY_W)) u_shreg (
    .clk     (clk),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_din   (w_payload),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_shift  = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid) begin
          w_accept = 1'b1;
          w_next   = S_SEND;
        end
      end
      S_SEND: begin
        // r_cnt counts payload bits still to be placed on the line
        if (r_cnt != '0) begin
          w_shift = 1'b1;
        end else begin
          w_last = 1'b1;
          w_next = (GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (r_gcnt == GAP_LAST) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_tx   <= IDLE_LEVEL;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_gcnt <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_tx  <= START_BIT;
        r_cnt <= CNT_LOAD;
      end else if (w_shift) begin
        r_tx  <= w_msb;
        r_cnt <= r_cnt - 1'b1;
      end else if (w_last) begin
        r_tx  <= IDLE_LEVEL;
      end
      if (r_state == S_GAP) begin
        r_gcnt <= (r_gcnt == GAP_LAST) ? '0 : r_gcnt + 1'b1;
      end else begin
        r_gcnt <= '0;
      end
    end
  end

  assign ready = (r_state == S_IDLE);
  assign tx    = r_tx;
  assign done  = r_done;

endmodule

// File: tb/tb_pctrl_tx.sv
// Self-checking bench for pctrl_tx: command table, scoreboard queue of expected
// frames, and hand-written sequences for timing, busy-ignore and mid-frame reset.
module tb_pctrl_tx;

`ifdef PCTRL_TX_PARITY_EN
  localparam int FW = 75;
`else
  localparam int FW = 74;
`endif
  localparam int TB_GAP = 2;

  typedef struct {
    logic [7:0]  a;
    logic [2:0]  o;
    logic [61:0] d;
    logic        p;
  } cmd_t;

  typedef struct {
    logic [FW-1:0] f;
    int            acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        nRst;
  logic        valid;
  logic        ready;
  logic [7:0]  address;
  logic [2:0]  opcode;
  logic [61:0] data;
  logic        tx;
  logic        done;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  cmd_t tbl[6];

  pctrl_tx #(.ADDR_W(8), .OP_W(3), .DATA_W(62), .GAP(TB_GAP)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .valid   (valid),
    .ready   (ready),
    .address (address),
    .opcode  (opcode),
    .data    (data),
    .tx      (tx),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] build(input cmd_t c);
`ifdef PCTRL_TX_PARITY_EN
    return {1'b0, c.a, c.o, c.d, c.p};
`else
    return {1'b0, c.a, c.o, c.d};
`endif
  endfunction

  task automatic wait_cyc(input int t);
    int n;
    n = 0;
    while (cyc < t && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Drive a command and wait for its accept edge; leaves valid asserted.
  task automatic send(input cmd_t c, output int acc);
    int   n;
    exp_t e;
    address = c.a;
    opcode  = c.o;
    data    = c.d;
    valid   = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc   = cyc;
      e.f   = build(c);
      e.acc = acc;
      q.push_back(e);
    end
  endtask

  // Line monitor: collects each frame from its start bit and scores it.
  initial begin
    int            ms;
    int            nb;
    int            sc;
    logic [FW-1:0] fr;
    exp_t          e;
    ms = 0;
    nb = 0;
    sc = 0;
    fr = '1;
    forever begin
      @(negedge clk);
      if (nRst !== 1'b1) begin
        ms = 0;
        nb = 0;
      end else begin
        case (ms)
          0: begin
            if (done !== 1'b0) chk("spurious_done", done, 0);
            if (tx === 1'b0) begin
              fr = '1;
              fr[FW-1] = tx;
              nb = 1;
              sc = cyc;
              ms = 1;
            end
          end
          1: begin
            fr[FW-1-nb] = tx;
            nb++;
            if (nb == FW) ms = 2;
          end
          default: begin
            chk("frame_end_tx", tx, 1);
            chk("frame_done", done, 1);
            if (q.size() == 0) begin
              chk("unexpected_frame", 1, 0);
            end else begin
              e = q.pop_front();
              chk("frame_bits", fr, e.f);
              chk("start_latency", sc, e.acc);
            end
            ms = 0;
          end
        endcase
      end
    end
  end

  initial begin
    int acc;
    int prev;
    int bad;
    int n;

    tbl[0] = '{8'hAA, 3'd4, 62'd100, 1'b0};
    tbl[1] = '{8'h55, 3'd1, 62'h3FFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[2] = '{8'hAB, 3'd4, 62'd100, 1'b1};
    tbl[3] = '{8'h00, 3'd0, 62'd0, 1'b0};
    tbl[4] = '{8'hFF, 3'd7, 62'h3FFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[5] = '{8'h01, 3'd2, 62'd1, 1'b1};

    nRst    = 1'b0;
    valid   = 1'b0;
    address = '0;
    opcode  = '0;
    data    = '0;

    #50;
    chk("reset_tx", tx, 1);
    chk("reset_done", done, 0);
    chk("reset_ready", ready, 1);
    #50;
    nRst = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) bad++;
    end
    chk("idle_1000_cycles", bad, 0);

    // Single frame with done/ready timing.
    send(tbl[0], acc);
    valid = 1'b0;
    wait_cyc(acc + FW - 1);
    chk("done_not_early", done, 0);
    chk("busy_ready", ready, 0);
    wait_cyc(acc + FW);
    chk("done_pulse", done, 1);
    chk("tx_high_after_frame", tx, 1);
    wait_cyc(acc + FW + 1);
    chk("done_one_cycle", done, 0);
    wait_cyc(acc + FW + TB_GAP - 1);
    chk("ready_held_in_gap", ready, 0);
    wait_cyc(acc + FW + TB_GAP);
    chk("ready_return", ready, 1);

    // Table, back-to-back with valid held high.
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i], acc);
      if (i > 0) chk("b2b_spacing", acc - prev, FW + TB_GAP + 1);
      prev = acc;
    end
    valid = 1'b0;

    // Inputs changing while busy must not disturb the frame.
    send('{8'h3C, 3'd6, 62'h0123_4567_89AB_CDEF, 1'b0}, acc);
    valid = 1'b0;
    wait_cyc(acc + 10);
    address = 8'hFF;
    opcode  = 3'd1;
    data    = '1;
    wait_cyc(acc + 40);
    address = 8'h00;
    opcode  = 3'd0;
    data    = '0;

    // Reset in the middle of a frame.
    send(tbl[0], acc);
    valid = 1'b0;
    wait_cyc(acc + 30);
    chk("pre_reset_tx", tx, 0);
    #2;
    nRst = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_done", done, 0);
    repeat (2) @(negedge clk);
    q.delete();
    chk("reset_mid_ready", ready, 1);
    nRst = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", ready, 1);
    chk("post_reset_tx", tx, 1);
    send(tbl[2], acc);
    valid = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", q.size(), 0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
